// File: rtl/xfer_ctrl.sv
// xfer_ctrl: Moore transfer FSM with retry/interrupt cool-down; optional ack responder (XFER_ACK_EN).
module xfer_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] len,
  input  logic       abort,
  input  logic       fault,
  input  logic       rt,
  input  logic       irq,
  input  logic       req,
  output logic       rdy,
  output logic       start,
  output logic       endd,
  output logic       stop,
  output logic       er,
  output logic       status_valid,
  output logic       enable,
  output logic       ack,
  output logic [3:0] beat_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_RUN = 3'd2, S_TERM = 3'd3, S_COOL = 3'd4;
  localparam logic [1:0] K_END = 2'd0, K_STOP = 2'd1, K_ER = 2'd2;
  logic [2:0] r_state, w_next;
  logic [1:0] r_kind, w_kind;
  logic [3:0] r_beat;
  logic       r_first, r_cool, r_sv;
  logic       w_int;
  assign w_int = rt | irq;
  always_comb begin
    w_next = r_state;
    w_kind = r_kind;
    case (r_state)
      S_IDLE:  w_next = w_int ? S_COOL : S_ARMED;
      S_ARMED: w_next = w_int ? S_COOL : go ? S_RUN : S_ARMED;
      S_RUN: begin
        if (w_int) w_next = S_COOL;
        else if (abort) begin w_next = S_TERM; w_kind = K_STOP; end
        else if (fault) begin w_next = S_TERM; w_kind = K_ER; end
        else if (r_beat == 4'd1) begin w_next = S_TERM; w_kind = K_END; end
      end
      S_TERM:  w_next = S_COOL;
      S_COOL:  w_next = (!w_int && r_cool) ? S_ARMED : S_COOL;
      default: w_next = S_IDLE;
    endcase
  end
  // r_cool marks the second COOL cycle; any rt/irq in COOL rewinds it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kind  <= K_END;
      r_beat  <= 4'd0;
      r_first <= 1'b0;
      r_cool  <= 1'b0;
      r_sv    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_kind  <= w_kind;
      r_first <= (r_state == S_ARMED) && (w_next == S_RUN);
      r_cool  <= (r_state == S_COOL) && !w_int && !r_cool;
      r_sv    <= (r_state == S_TERM) && (r_kind == K_END);
      if ((r_state == S_ARMED) && (w_next == S_RUN)) r_beat <= (len == 4'd0) ? 4'd1 : len;
      else if ((r_state == S_RUN) && (r_beat != 4'd0)) r_beat <= r_beat - 4'd1;
    end
  end
  assign rdy          = (r_state == S_ARMED) || (r_state == S_RUN) || (r_state == S_TERM);
  assign enable       = (r_state == S_RUN);
  assign start        = (r_state == S_RUN) && r_first;
  assign endd         = (r_state == S_TERM) && (r_kind == K_END);
  assign stop         = (r_state == S_TERM) && (r_kind == K_STOP);
  assign er           = (r_state == S_TERM) && (r_kind == K_ER);
  assign status_valid = r_sv;
  assign beat_cnt     = r_beat;
`ifdef XFER_ACK_EN
  logic [1:0] r_ack_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ack_cnt <= 2'd0;
    else if (r_ack_cnt != 2'd0) r_ack_cnt <= r_ack_cnt - 2'd1;
    else if (req) r_ack_cnt <= 2'd3;
  end
  assign ack = (r_ack_cnt != 2'd0);
`else
  logic w_unused;
  assign w_unused = req;
  assign ack      = 1'b0;
`endif
endmodule

// File: tb/tb_xfer_ctrl.sv
// tb_xfer_ctrl: randomized and directed checks of xfer_ctrl against a transaction-level trace model.
module tb_xfer_ctrl;
  logic       clk = 1'b0, rst = 1'b1, go = 1'b0, abort = 1'b0, fault = 1'b0, rt = 1'b0, irq = 1'b0, req = 1'b0;
  logic [3:0] len = 4'd0;
  logic       rdy, start, endd, stop, er, status_valid, enable, ack;
  logic [3:0] beat_cnt;
  int         n_cmp = 0, n_bad = 0;
  localparam logic [6:0] V_RDY = 7'b1000000, V_START = 7'b0100000, V_ENDD = 7'b0010000,
                         V_STOP = 7'b0001000, V_ER = 7'b0000100, V_SV = 7'b0000010, V_EN = 7'b0000001;
  always #5 clk = ~clk;
  xfer_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .len(len), .abort(abort), .fault(fault), .rt(rt), .irq(irq),
    .req(req), .rdy(rdy), .start(start), .endd(endd), .stop(stop), .er(er),
    .status_valid(status_valid), .enable(enable), .ack(ack), .beat_cnt(beat_cnt)
  );
  function automatic logic [6:0] obs();
    return {rdy, start, endd, stop, er, status_valid, enable};
  endfunction
  // expected output vector at cycle j after go (j=1 is first RUN cycle); RUN ends at cycle e
  // kind: 0 completion, 1 abort, 2 fault, 3 rt/irq
  function automatic logic [6:0] model(int j, int e, int kind);
    if (j <= e) return V_RDY | V_EN | ((j == 1) ? V_START : 7'b0);
    if (kind == 3) return (j <= e + 2) ? 7'b0 : V_RDY;
    if (j == e + 1) return V_RDY | ((kind == 0) ? V_ENDD : (kind == 1) ? V_STOP : V_ER);
    if (j == e + 2) return (kind == 0) ? V_SV : 7'b0;
    if (j == e + 3) return 7'b0;
    return V_RDY;
  endfunction
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({obs(), beat_cnt, ack} !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 0", {obs(), beat_cnt, ack});
    end
    rt  = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      rt = 1'b0;
      n_cmp++;
      if (obs() !== ((c == 3) ? V_RDY : 7'b0)) begin
        n_bad++;
        $display("FAIL idle_rt_cool c%0d: got %b want %b", c, obs(), (c == 3) ? V_RDY : 7'b0);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== V_RDY) begin
      n_bad++;
      $display("FAIL first_edge_idle: got %b want %b", obs(), V_RDY);
    end
  endtask
  task automatic test_xfer(input int lv, input int ta, input int tf, input int tr, input int ti, input string nm);
    int  L, e, kind, last;
    bit  done;
    L = (lv == 0) ? 1 : lv;
    e = L;
    kind = 0;
    done = 0;
    for (int k = 1; k <= L && !done; k++) begin
      if (k == tr || k == ti) begin e = k; kind = 3; done = 1; end
      else if (k == ta) begin e = k; kind = 1; done = 1; end
      else if (k == tf) begin e = k; kind = 2; done = 1; end
    end
    last = (kind == 3) ? e + 3 : e + 4;
    n_cmp++;
    if (obs() !== V_RDY) begin
      n_bad++;
      $display("FAIL %s armed: got %b want %b", nm, obs(), V_RDY);
    end
    go  = 1'b1;
    len = lv[3:0];
    @(negedge clk);
    go = 1'b0;
    for (int j = 1; j <= last; j++) begin
      n_cmp++;
      if (obs() !== model(j, e, kind)) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got %b want %b", nm, j, obs(), model(j, e, kind));
      end
      if (j <= e) begin
        n_cmp++;
        if (beat_cnt !== 4'(L - j + 1)) begin
          n_bad++;
          $display("FAIL %s beat%0d: got %0d want %0d", nm, j, beat_cnt, L - j + 1);
        end
      end
      rt    = (j == tr) && (j <= e);
      irq   = (j == ti) && (j <= e);
      abort = (j == ta) && (j <= e);
      fault = (j == tf) && (j <= e);
      if (j < last) @(negedge clk);
    end
    {rt, irq, abort, fault} = 4'b0;
  endtask
  task automatic test_cool_restart();
    logic [6:0] exp_v [6];
    exp_v = '{V_RDY | V_EN | V_START, 7'b0, 7'b0, 7'b0, V_RDY, 7'b0};
    go  = 1'b1;
    len = 4'd8;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (obs() !== exp_v[c]) begin
        n_bad++;
        $display("FAIL cool_restart c%0d: got %b want %b", c, obs(), exp_v[c]);
      end
      rt = (c <= 1);
      @(negedge clk);
    end
    rt = 1'b0;
    irq = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      irq = 1'b0;
      n_cmp++;
      if (obs() !== ((c == 2) ? V_RDY : 7'b0)) begin
        n_bad++;
        $display("FAIL armed_irq c%0d: got %b want %b", c, obs(), (c == 2) ? V_RDY : 7'b0);
      end
    end
  endtask
  task automatic test_ack();
`ifdef XFER_ACK_EN
    logic [8:0] pulse_exp, held_exp;
    pulse_exp = 9'b000001110;
    held_exp  = 9'b011101110;
    req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req = 1'b0;
      n_cmp++;
      if (ack !== pulse_exp[c]) begin
        n_bad++;
        $display("FAIL ack_pulse c%0d: got %b want %b", c, ack, pulse_exp[c]);
      end
    end
    req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 5) req = 1'b0;
      n_cmp++;
      if (ack !== held_exp[c]) begin
        n_bad++;
        $display("FAIL ack_held c%0d: got %b want %b", c, ack, held_exp[c]);
      end
    end
`else
    for (int c = 0; c < 12; c++) begin
      req = (c < 6) ? 1'b1 : 1'($urandom_range(1, 0));
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
        n_bad++;
        $display("FAIL ack_tied c%0d: got %b want 0", c, ack);
      end
    end
    req = 1'b0;
`endif
  endtask
  task automatic test_random();
    int lv, Lr, ev[4];
    for (int t = 0; t < 30; t++) begin
      lv = int'($urandom_range(15, 0));
      Lr = (lv == 0) ? 1 : lv;
      for (int i = 0; i < 4; i++) ev[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(Lr, 1)) : 0;
      test_xfer(lv, ev[0], ev[1], ev[2], ev[3], "rand");
    end
  endtask
  task automatic test_async_reset();
    go  = 1'b1;
    len = 4'd9;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({obs(), beat_cnt} !== 11'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b want 0", {obs(), beat_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== V_RDY) begin
      n_bad++;
      $display("FAIL post_reset_armed: got %b want %b", obs(), V_RDY);
    end
    test_xfer(2, 0, 0, 0, 0, "after_reset");
  endtask
  initial begin
    test_reset();
    test_xfer(3, 0, 0, 0, 0, "basic_len3");
    test_xfer(0, 0, 0, 0, 0, "len0");
    test_xfer(5, 2, 0, 0, 0, "abort2");
    test_xfer(6, 0, 0, 3, 0, "rt_run");
    test_xfer(4, 0, 2, 0, 2, "fault_irq");
    test_xfer(4, 0, 2, 0, 0, "fault");
    test_xfer(15, 0, 0, 0, 0, "len15");
    test_cool_restart();
    test_ack();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
